switch_conditioner: RTL and testbench

Parametrised front-end for asynchronous board switches. It synchronises N_CH switch inputs, debounces each one independently, and produces per-channel debounced levels and one-cycle rise/fall pulses. It also drives LED outputs in either direct-level or toggle mode. It sits between the raw pins and downstream logic, in place of the fixed 2-bit two-flop synchroniser and switch driver pair.

---
 rtl/switch_conditioner.sv | 115 +++++++++++
 tb/tb_switch_conditioner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/switch_conditioner.sv
// -----------------------------------------------------------------------------
// switch_conditioner
//
// Front-end for asynchronous board switches. Each of N_CH channels is
// synchronised through a SYNC_STAGES-deep flop chain, then debounced: a new
// level is accepted only after the synchronised input has differed from the
// current level for DEBOUNCE_CYCLES consecutive cycles. The accepted level is
// published together with one-cycle rise/fall pulses, and an LED output shows
// either the level itself or a per-channel toggle that flips on every rise.
//
// Ports:
//   i_clk    in   1     clock, all state on the rising edge
//   i_rst    in   1     asynchronous active-high reset, clears all state
//   i_mode   in   1     LED source: 0 = debounced level, 1 = toggle register
//   i_sw     in   N_CH  raw asynchronous switch inputs
//   o_level  out  N_CH  debounced, registered level
//   o_rise   out  N_CH  one-cycle pulse on a 0->1 change of o_level
//   o_fall   out  N_CH  one-cycle pulse on a 1->0 change of o_level
//   o_led    out  N_CH  registered LED drive
// -----------------------------------------------------------------------------
module switch_conditioner #(
    parameter int N_CH            = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mode,
    input  logic [N_CH-1:0] i_sw,
    output logic [N_CH-1:0] o_level,
    output logic [N_CH-1:0] o_rise,
    output logic [N_CH-1:0] o_fall,
    output logic [N_CH-1:0] o_led
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Count value at which the next differing sample commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchroniser chain: index 0 samples the pins, the top index is the
    // metastability-settled copy that feeds the debouncer.
    logic [SYNC_STAGES-1:0][N_CH-1:0] sync_q, sync_d;
    logic [N_CH-1:0]                  s;

    logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0]            level_q, level_d;
    logic [N_CH-1:0]            rise_q, rise_d;
    logic [N_CH-1:0]            fall_q, fall_d;
    logic [N_CH-1:0]            tgl_q, tgl_d;
    logic [N_CH-1:0]            led_q, led_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every signal gets a default before any conditional assignment,
        // so no path leaves a value unassigned and no latch is inferred.
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_sw};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;

        for (int i = 0; i < N_CH; i++) begin
            if (s[i] == level_q[i]) begin
                // Input agrees with the accepted level: any partial run of
                // differing samples (a glitch) is forgotten.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // DEBOUNCE_CYCLES-th consecutive differing sample: commit.
                level_d[i] = s[i];
                cnt_d[i]   = '0;
                rise_d[i]  = s[i];
                fall_d[i]  = ~s[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        // The toggle flips on the same edge that publishes the rise pulse.
        tgl_d = tgl_q ^ rise_d;

        // The LED samples the already-registered source, so it trails the
        // level/toggle by one edge but follows i_mode after a single edge.
        led_d = i_mode ? tgl_q : level_q;
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            tgl_q   <= '0;
            led_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            tgl_q   <= tgl_d;
            led_q   <= led_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_led   = led_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// -----------------------------------------------------------------------------
// tb_switch_conditioner
//
// Directed bench for switch_conditioner with N_CH=2, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4. Inputs change 1 time unit after a rising edge, so the
// next rising edge is "edge 1" for that change; outputs are sampled at the
// same point, away from the active edge. A committed change therefore shows
// after edge 6 and the LED follows after edge 7.
// -----------------------------------------------------------------------------
module tb_switch_conditioner;

    localparam int N_CH = 2;

    logic            clk;
    logic            rst;
    logic            mode;
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] led;

    int passed = 0;
    int total  = 0;

    switch_conditioner #(
        .N_CH            (2),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_mode  (mode),
        .i_sw    (sw),
        .o_level (level),
        .o_rise  (rise),
        .o_fall  (fall),
        .o_led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        sw   = 2'b00;
        tick_n(3);
        check("rst_level", level, 2'b00);
        check("rst_rise",  rise,  2'b00);
        check("rst_fall",  fall,  2'b00);
        check("rst_led",   led,   2'b00);
        rst = 1'b0;
        tick_n(3);
        check("idle_level", level, 2'b00);

        // ---- Latency: ch0 rise then fall, mode 0 ----
        sw = 2'b01;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("lat_rise_wait_level", level, 2'b00);
            check("lat_rise_wait_pulse", rise,  2'b00);
        end
        tick(); // edge 6
        check("lat_rise_level", level, 2'b01);
        check("lat_rise_pulse", rise,  2'b01);
        check("lat_rise_nofall", fall, 2'b00);
        check("lat_rise_led_e6", led,  2'b00);
        tick(); // edge 7
        check("lat_rise_pulse_end", rise, 2'b00);
        check("lat_rise_led_e7",    led,  2'b01);

        sw = 2'b00;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("lat_fall_wait_level", level, 2'b01);
            check("lat_fall_wait_pulse", fall,  2'b00);
        end
        tick(); // edge 6
        check("lat_fall_level",  level, 2'b00);
        check("lat_fall_pulse",  fall,  2'b01);
        check("lat_fall_norise", rise,  2'b00);
        tick(); // edge 7
        check("lat_fall_pulse_end", fall, 2'b00);
        check("lat_fall_led",       led,  2'b00);

        // ---- Glitch: 3-cycle pulse on ch1 is rejected ----
        sw = 2'b10;
        tick_n(3);
        sw = 2'b00;
        for (int e = 0; e < 8; e++) begin
            check("glitch_level", level, 2'b00);
            check("glitch_rise",  rise,  2'b00);
            check("glitch_led",   led,   2'b00);
            tick();
        end

        // ---- 4-cycle pulse on ch1 is accepted, then falls back ----
        sw = 2'b10;
        tick_n(4);
        sw = 2'b00;
        tick_n(2); // edge 6
        check("pulse4_level", level, 2'b10);
        check("pulse4_rise",  rise,  2'b10);
        tick(); // edge 7
        check("pulse4_led", led, 2'b10);
        tick_n(3); // edge 10
        check("pulse4_fall_level", level, 2'b00);
        check("pulse4_fall_pulse", fall,  2'b10);
        tick_n(3);

        // ---- Reset mid-run with both switches held ----
        sw = 2'b11;
        tick_n(7);
        check("pre_rst_level", level, 2'b11);
        check("pre_rst_led",   led,   2'b11);
        #2;
        rst = 1'b1;
        #1; // still before the next rising edge
        check("async_rst_level", level, 2'b00);
        check("async_rst_led",   led,   2'b00);
        check("async_rst_rise",  rise,  2'b00);
        tick();
        rst = 1'b0;
        tick_n(5);
        check("post_rst_wait_level", level, 2'b00);
        tick(); // edge 6 after release
        check("post_rst_level", level, 2'b11);
        check("post_rst_rise",  rise,  2'b11);
        tick(); // edge 7
        check("post_rst_rise_end", rise, 2'b00);
        check("post_rst_led",      led,  2'b11);

        // Fresh state for the toggle test: switches low, toggles cleared.
        sw = 2'b00;
        tick_n(8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick_n(2);

        // ---- Toggle mode: three presses on ch0 ----
        mode = 1'b1;
        tick();
        check("tgl_initial_led", led, 2'b00);
        for (int p = 0; p < 3; p++) begin
            logic [1:0] before_led;
            logic [1:0] after_led;
            before_led = (p % 2 == 1) ? 2'b01 : 2'b00;
            after_led  = (p % 2 == 0) ? 2'b01 : 2'b00;
            sw = 2'b01;
            tick_n(6);
            check("tgl_press_rise",   rise, 2'b01);
            check("tgl_press_led_e6", led,  before_led);
            tick();
            check("tgl_press_led_e7", led,  after_led);
            sw = 2'b00;
            tick_n(8);
            check("tgl_release_level", level, 2'b00);
            check("tgl_release_led",   led,   after_led);
        end

        // ---- Mode switch with tgl[0]=1, level[0]=0 ----
        mode = 1'b0;
        #1;
        check("mode_hold_before_edge", led, 2'b01);
        tick();
        check("mode_to_level", led, 2'b00);
        mode = 1'b1;
        tick();
        check("mode_to_toggle", led, 2'b01);

        // ---- Reset mid-debounce on ch0 ----
        sw = 2'b01;
        tick_n(4);
        check("mid_rst_no_rise",  rise,  2'b00);
        check("mid_rst_no_level", level, 2'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("mid_rst_wait_rise", rise, 2'b00);
        end
        tick(); // edge 6 after release
        check("mid_rst_rise",  rise,  2'b01);
        check("mid_rst_level", level, 2'b01);
        tick(); // edge 7: toggle was cleared by reset, now flipped to 1
        check("mid_rst_led", led, 2'b01);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
